// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift_sipo_frame deserialiser.
// Holds the framing FSM encoding and the bit counter width helper.
package shift_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PARITY  = 1'b1
    } state_t;

    // Counter width: ceil(log2(width)), never below one bit.
    function automatic int calc_cw(input int width);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < width) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/shift_sipo_frame.sv
// Parametrised serial-in/parallel-out deserialiser with word strobe and framing clear.
// Optional parity bit after each word is enabled by defining SHIFT_SIPO_PARITY_EN.
module shift_sipo_frame
    import shift_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_ODD = 0,
    localparam int CW        = calc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             s_en,
    input  logic             s_in,
    output logic [WIDTH-1:0] q_live,
    output logic [WIDTH-1:0] q_out,
    output logic             word_valid,
    output logic [CW-1:0]    bit_cnt,
    output logic             parity_err
);

`ifdef SHIFT_SIPO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // Serial handshake: a bit is taken on every rising edge where s_en is high;
    // there is no backpressure, the source must hold s_in valid with s_en.

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;

    always_comb begin
        if (MSB_FIRST != 0) shifted = {q_live[WIDTH-2:0], s_in};
        else                shifted = {s_in, q_live[WIDTH-1:1]};
    end

    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_COLLECT;
        end else if (s_en) begin
            case (state)
                ST_COLLECT: if (PAR_EN && last_bit) state_nxt = ST_PARITY;
                ST_PARITY:  state_nxt = ST_COLLECT;
                default:    state_nxt = ST_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_live     <= '0;
            q_out      <= '0;
            word_valid <= 1'b0;
            bit_cnt    <= '0;
            parity_err <= 1'b0;
        end else if (clr) begin
            // Realign framing; the last completed word stays visible.
            q_live     <= '0;
            bit_cnt    <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (s_en) begin
                if (state == ST_COLLECT) begin
                    q_live <= shifted;
                    if (last_bit) begin
                        bit_cnt <= '0;
                        if (!PAR_EN) begin
                            q_out      <= shifted;
                            word_valid <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end else begin
                    // Parity bit: q_live already holds the full data word.
                    q_out      <= q_live;
                    word_valid <= 1'b1;
                    parity_err <= (^q_live) ^ s_in ^ PARITY_ODD[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_sipo_frame.sv
// Self-checking bench for shift_sipo_frame: MSB-first and LSB-first instances share one
// serial stream and are compared every cycle against a bit-history model.
module tb_shift_sipo_frame;

    localparam int W = 8;
`ifdef SHIFT_SIPO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic s_en = 1'b0;
    logic s_in = 1'b0;

    logic [W-1:0] m_q_live, m_q_out, l_q_live, l_q_out;
    logic         m_word_valid, l_word_valid, m_parity_err, l_parity_err;
    logic [2:0]   m_bit_cnt, l_bit_cnt;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    shift_sipo_frame #(.WIDTH(W), .MSB_FIRST(1), .PARITY_ODD(0)) dut_m (
        .clk(clk), .rst(rst), .clr(clr), .s_en(s_en), .s_in(s_in),
        .q_live(m_q_live), .q_out(m_q_out), .word_valid(m_word_valid),
        .bit_cnt(m_bit_cnt), .parity_err(m_parity_err)
    );

    shift_sipo_frame #(.WIDTH(W), .MSB_FIRST(0), .PARITY_ODD(0)) dut_l (
        .clk(clk), .rst(rst), .clr(clr), .s_en(s_en), .s_in(s_in),
        .q_live(l_q_live), .q_out(l_q_out), .word_valid(l_word_valid),
        .bit_cnt(l_bit_cnt), .parity_err(l_parity_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- model ----------------
    // hist: most recent data bits shifted in (oldest first); frame: bits of current frame.
    bit       hist[$];
    bit       frame[$];
    bit       in_par = 1'b0;
    logic [W-1:0] mo_m = '0, mo_l = '0;
    logic     mv = 1'b0;
    logic     mperr = 1'b0;

    function automatic logic [W-1:0] live_word(input bit msb);
        logic [W-1:0] w;
        int idx;
        w = '0;
        for (int i = 0; i < W; i++) begin
            idx = hist.size() - 1 - i;
            if (idx >= 0) begin
                if (msb) w[i] = hist[idx];
                else     w[W-1-i] = hist[idx];
            end
        end
        return w;
    endfunction

    function automatic logic [W-1:0] compose(input bit msb);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < W; k++) begin
            if (msb) w[W-1-k] = frame[k];
            else     w[k] = frame[k];
        end
        return w;
    endfunction

    function automatic bit frame_parity();
        bit p;
        p = 1'b0;
        foreach (frame[k]) p ^= frame[k];
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete(); frame.delete();
            in_par = 1'b0; mo_m = '0; mo_l = '0; mv = 1'b0; mperr = 1'b0;
        end else if (clr) begin
            hist.delete(); frame.delete();
            in_par = 1'b0; mv = 1'b0;
        end else begin
            mv = 1'b0;
            if (s_en) begin
                if (in_par) begin
                    frame.push_back(s_in);
                    mo_m = compose(1'b1);
                    mo_l = compose(1'b0);
                    mperr = frame_parity();
                    mv = 1'b1;
                    frame.delete();
                    in_par = 1'b0;
                end else begin
                    hist.push_back(s_in);
                    if (hist.size() > W) void'(hist.pop_front());
                    frame.push_back(s_in);
                    if (frame.size() == W) begin
                        if (PAR) begin
                            in_par = 1'b1;
                        end else begin
                            mo_m = compose(1'b1);
                            mo_l = compose(1'b0);
                            mv = 1'b1;
                            frame.delete();
                        end
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        logic [31:0] exp_cnt;
        exp_cnt = in_par ? 0 : frame.size();
        check("m_q_live", 32'(m_q_live), 32'(live_word(1'b1)));
        check("l_q_live", 32'(l_q_live), 32'(live_word(1'b0)));
        check("m_q_out", 32'(m_q_out), 32'(mo_m));
        check("l_q_out", 32'(l_q_out), 32'(mo_l));
        check("m_word_valid", 32'(m_word_valid), 32'(mv));
        check("l_word_valid", 32'(l_word_valid), 32'(mv));
        check("m_bit_cnt", 32'(m_bit_cnt), exp_cnt);
        check("l_bit_cnt", 32'(l_bit_cnt), exp_cnt);
        check("m_parity_err", 32'(m_parity_err), 32'(PAR ? mperr : 1'b0));
        check("l_parity_err", 32'(l_parity_err), 32'(PAR ? mperr : 1'b0));
    end

    // ---------------- driver ----------------
    task automatic drive(input logic en, input logic b, input logic c);
        s_en = en;
        s_in = b;
        clr = c;
        @(negedge clk);
    endtask

    // Sends v MSB-first, then the parity bit pbit when parity framing is built in.
    task automatic send_frame(input logic [W-1:0] v, input logic pbit, input bit gaps);
        for (int i = 0; i < W; i++) begin
            drive(1'b1, v[W-1-i], 1'b0);
            if (gaps && (i < W - 1 || PAR)) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        if (PAR) drive(1'b1, pbit, 1'b0);
    endtask

    task automatic expect_word(input string tag, input logic [W-1:0] em, input logic [W-1:0] el);
        check({tag, "_q_out_m"}, 32'(m_q_out), 32'(em));
        check({tag, "_q_out_l"}, 32'(l_q_out), 32'(el));
        check({tag, "_valid"}, 32'(m_word_valid), 32'd1);
        check({tag, "_cnt"}, 32'(m_bit_cnt), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        check({tag, "_valid_drop"}, 32'(m_word_valid), 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        @(negedge clk);
        @(negedge clk);
        check("rst_q_out", 32'(m_q_out), 32'd0);
        check("rst_q_live", 32'(m_q_live), 32'd0);
        check("rst_valid", 32'(m_word_valid), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        // Basic word, both bit orders from one stream.
        send_frame(8'h1F, 1'b1, 1'b0);
        check("model_pin_1f", 32'(mo_m), 32'h1F);
        expect_word("w1f", 8'h1F, 8'hF8);

        // Same word with idle gaps between enabled bits.
        send_frame(8'h1F, 1'b1, 1'b1);
        expect_word("gap", 8'h1F, 8'hF8);

        // Clear mid-frame with s_en high: that bit is dropped, q_out retained.
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        check("clr_cnt", 32'(m_bit_cnt), 32'd0);
        check("clr_q_live", 32'(m_q_live), 32'd0);
        check("clr_keep_q_out", 32'(m_q_out), 32'h1F);
        send_frame(8'h3C, 1'b0, 1'b0);
        expect_word("clr3c", 8'h3C, 8'h3C);

        // Back-to-back words: pulses exactly one frame apart.
        send_frame(8'hA5, 1'b0, 1'b0);
        t0 = cyc;
        check("b2b_a5", 32'(m_q_out), 32'hA5);
        check("b2b_a5_valid", 32'(m_word_valid), 32'd1);
        send_frame(8'h3C, 1'b0, 1'b0);
        t1 = cyc;
        check("b2b_3c", 32'(m_q_out), 32'h3C);
        check("b2b_3c_valid", 32'(m_word_valid), 32'd1);
        check("b2b_spacing", 32'(t1 - t0), 32'(W + (PAR ? 1 : 0)));

        // Parity sense (A5 has even weight): flag follows the parity bit.
        send_frame(8'hA5, 1'b0, 1'b0);
        check("par0_err", 32'(m_parity_err), 32'd0);
        expect_word("par0", 8'hA5, 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("par1_err", 32'(m_parity_err), 32'(PAR ? 1 : 0));
        expect_word("par1", 8'hA5, 8'hA5);

        // Random frames with random gaps, checked by the per-cycle compare.
        for (int f = 0; f < 4; f++) begin
            send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drive(1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges mid-frame.
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        s_en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_q_live", 32'(m_q_live), 32'd0);
        check("arst_q_out", 32'(m_q_out), 32'd0);
        check("arst_valid", 32'(m_word_valid), 32'd0);
        check("arst_cnt", 32'(m_bit_cnt), 32'd0);
        check("arst_perr", 32'(m_parity_err), 32'd0);
        check("arst_l_q_out", 32'(l_q_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0);
        expect_word("post_rst", 8'h5A, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
